// File: rtl/alu_op_sequencer_if.sv
// Bundles the decode-stage request/response and the ALU_16Slice control/status lines.
// Latency: none, wiring only.
// Backpressure: Busy from the sequencer; a Start raised while Busy is dropped, not queued.
interface alu_op_sequencer_if;
    // decode-stage request
    logic        Start;
    logic [3:0]  Op;
    logic [3:0]  ShAmt;
    logic [15:0] OpA;
    logic [15:0] OpB;

    // decode-stage response and architectural flags
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        FlagC;
    logic        FlagZ;
    logic        FlagN;

    // slice operands and status
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] ALUOut;
    logic        COut;
    logic        nZ;
    logic        Sum;

    // slice arithmetic controls
    logic        CIn;
    logic        SUB;
    logic        ZeroA;
    logic        FAOut;

    // slice logic selects
    logic        AND;
    logic        OR;
    logic        XOR;
    logic        NOT;
    logic        NAND;
    logic        NOR;

    // slice shifter controls
    logic        Sign;
    logic        ShSignIn;
    logic        Sh1;
    logic        Sh2;
    logic        Sh4;
    logic        Sh8;
    logic        ShB;
    logic        ShL;
    logic        ShR;
    logic        ShOut;

    // LLI select and slice output enable
    logic        LLI;
    logic        ALUEnable;

    // master: the sequencer, which drives the slice and answers the decode stage
    modport master (
        input  Start, Op, ShAmt, OpA, OpB, ALUOut, COut, nZ, Sum,
        output Busy, Done, Result, FlagC, FlagZ, FlagN, A, B,
               CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR,
               Sign, ShSignIn, Sh1, Sh2, Sh4, Sh8, ShB, ShL, ShR, ShOut,
               LLI, ALUEnable
    );

    // slave: the environment made of the decode stage plus the slice datapath
    modport slave (
        output Start, Op, ShAmt, OpA, OpB, ALUOut, COut, nZ, Sum,
        input  Busy, Done, Result, FlagC, FlagZ, FlagN, A, B,
               CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR,
               Sign, ShSignIn, Sh1, Sh2, Sh4, Sh8, ShB, ShL, ShR, ShOut,
               LLI, ALUEnable
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU_16Slice op per request: latch, hold controls SETTLE cycles, capture result/flags.
// Latency: Done pulses SETTLE+1 cycles after the accepting edge; one op per SETTLE+2 cycles.
// Backpressure: Busy high in EVAL/DONE; Start is only sampled in IDLE and is otherwise dropped.
module alu_op_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic                Clock,
    input  logic                nReset,
    alu_op_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    // every slice control the sequencer can drive, registered as one word
    typedef struct packed {
        logic cin;
        logic sub;
        logic zero_a;
        logic fa_out;
        logic and_sel;
        logic or_sel;
        logic xor_sel;
        logic not_sel;
        logic nand_sel;
        logic nor_sel;
        logic sign;
        logic sh_sign_in;
        logic sh1;
        logic sh2;
        logic sh4;
        logic sh8;
        logic sh_b;
        logic sh_l;
        logic sh_r;
        logic sh_out;
        logic lli;
        logic alu_enable;
    } ctrl_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    ctrl_t       ctrl, ctrl_nxt;
    logic        accept;
    logic        capture;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] result;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;

    // Opcode to control decode. The carry flag is frozen for the whole EVAL
    // window, so ADC/SBC can pick it up at acceptance time.
    function automatic ctrl_t decode(input logic [3:0] op, input logic [3:0] sh,
                                     input logic carry);
        ctrl_t d;
        d = '0;
        d.alu_enable = 1'b1;
        case (op)
            4'd0:  d.fa_out = 1'b1;
            4'd1:  begin d.fa_out = 1'b1; d.cin = carry; end
            4'd2:  begin d.fa_out = 1'b1; d.sub = 1'b1; d.cin = 1'b1; end
            4'd3:  begin d.fa_out = 1'b1; d.sub = 1'b1; d.cin = carry; end
            4'd4:  begin d.fa_out = 1'b1; d.zero_a = 1'b1; d.sub = 1'b1; d.cin = 1'b1; end
            4'd5:  begin d.fa_out = 1'b1; d.zero_a = 1'b1; end
            4'd6:  d.and_sel  = 1'b1;
            4'd7:  d.or_sel   = 1'b1;
            4'd8:  d.xor_sel  = 1'b1;
            4'd9:  d.not_sel  = 1'b1;
            4'd10: d.nand_sel = 1'b1;
            4'd11: d.nor_sel  = 1'b1;
            4'd12: begin
                d.sh_out = 1'b1;
                d.sh_l   = 1'b1;
                {d.sh8, d.sh4, d.sh2, d.sh1} = sh;
            end
            4'd13: begin
                d.sh_out = 1'b1;
                d.sh_r   = 1'b1;
                {d.sh8, d.sh4, d.sh2, d.sh1} = sh;
            end
            4'd14: begin
                d.sh_out     = 1'b1;
                d.sh_r       = 1'b1;
                d.sign       = 1'b1;
                d.sh_sign_in = 1'b1;
                {d.sh8, d.sh4, d.sh2, d.sh1} = sh;
            end
            default: begin
                d.sh_out = 1'b1;
                d.lli    = 1'b1;
            end
        endcase
        return d;
    endfunction

    // Next-state, settle counter and next control word
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ctrl_nxt  = ctrl;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                ctrl_nxt = '0;
                if (bus.Start) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'(SETTLE - 1);
                    ctrl_nxt  = decode(bus.Op, bus.ShAmt, flag_c);
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    capture   = 1'b1;
                    ctrl_nxt  = '0;
                    state_nxt = DONE;
                end
            end
            default: begin
                ctrl_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, operand latch, result capture and architectural flags
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state  <= IDLE;
            cnt    <= '0;
            ctrl   <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ctrl  <= ctrl_nxt;
            if (accept) begin
                op_q <= bus.Op;
                a_q  <= bus.OpA;
                b_q  <= bus.OpB;
            end
            if (capture) begin
                result <= bus.ALUOut;
                flag_z <= ~bus.nZ;
                flag_n <= bus.Sum;
                // only the adder ops produce a meaningful carry
                if (op_q < 4'd6) begin
                    flag_c <= bus.COut;
                end
            end
        end
    end

    assign bus.Busy      = (state != IDLE);
    assign bus.Done      = (state == DONE);
    assign bus.Result    = result;
    assign bus.FlagC     = flag_c;
    assign bus.FlagZ     = flag_z;
    assign bus.FlagN     = flag_n;
    assign bus.A         = a_q;
    assign bus.B         = b_q;

    assign bus.CIn       = ctrl.cin;
    assign bus.SUB       = ctrl.sub;
    assign bus.ZeroA     = ctrl.zero_a;
    assign bus.FAOut     = ctrl.fa_out;
    assign bus.AND       = ctrl.and_sel;
    assign bus.OR        = ctrl.or_sel;
    assign bus.XOR       = ctrl.xor_sel;
    assign bus.NOT       = ctrl.not_sel;
    assign bus.NAND      = ctrl.nand_sel;
    assign bus.NOR       = ctrl.nor_sel;
    assign bus.Sign      = ctrl.sign;
    assign bus.ShSignIn  = ctrl.sh_sign_in;
    assign bus.Sh1       = ctrl.sh1;
    assign bus.Sh2       = ctrl.sh2;
    assign bus.Sh4       = ctrl.sh4;
    assign bus.Sh8       = ctrl.sh8;
    assign bus.ShB       = ctrl.sh_b;
    assign bus.ShL       = ctrl.sh_l;
    assign bus.ShR       = ctrl.sh_r;
    assign bus.ShOut     = ctrl.sh_out;
    assign bus.LLI       = ctrl.lli;
    assign bus.ALUEnable = ctrl.alu_enable;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a control-driven slice model feeds the DUT, an op-level model predicts results.
// Latency: expects Done SETTLE+1 cycles after acceptance, one op per SETTLE+2 cycles.
// Backpressure: holds Start high through Busy and expects those requests to be ignored.
module tb_alu_op_sequencer;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if bif();

    alu_op_sequencer #(.SETTLE(SETTLE)) dut (
        .Clock  (clk),
        .nReset (nreset),
        .bus    (bif)
    );

    // Slice datapath model: reacts only to the control lines it is given
    always_comb begin
        logic [16:0] s;
        logic [15:0] o;
        logic        co;
        int          amt;
        s   = '0;
        o   = '0;
        co  = 1'b0;
        amt = {28'd0, bif.Sh8, bif.Sh4, bif.Sh2, bif.Sh1};
        if (bif.ALUEnable) begin
            if (bif.FAOut) begin
                s  = {1'b0, (bif.ZeroA ? 16'h0000 : bif.A)} + {1'b0, (bif.SUB ? ~bif.B : bif.B)}
                     + {16'd0, bif.CIn};
                o  = s[15:0];
                co = s[16];
            end else if (bif.AND)  o = bif.A & bif.B;
            else if (bif.OR)       o = bif.A | bif.B;
            else if (bif.XOR)      o = bif.A ^ bif.B;
            else if (bif.NOT)      o = ~bif.A;
            else if (bif.NAND)     o = ~(bif.A & bif.B);
            else if (bif.NOR)      o = ~(bif.A | bif.B);
            else if (bif.ShOut) begin
                if (bif.LLI)       o = {bif.A[15:8], bif.B[7:0]};
                else if (bif.ShL)  o = bif.A << amt;
                else if (bif.ShR)  o = bif.Sign ? 16'($signed(bif.A) >>> amt) : (bif.A >> amt);
            end
        end
        bif.ALUOut = o;
        bif.COut   = co;
        bif.nZ     = |o;
        bif.Sum    = o[15];
    end

    int checks = 0;
    int errors = 0;

    // architectural flag model and expectations for the last modelled op
    logic        m_c = 1'b0, m_z = 1'b0, m_n = 1'b0;
    logic [15:0] exp_res;
    logic [21:0] exp_ctrl;

    // observations from the last do_op
    logic [15:0] obs_res, obs_a, obs_b;
    logic        obs_c, obs_z, obs_n;
    logic [21:0] obs_ctrl, obs_ctrl_done;
    int          obs_cyc, obs_busy;
    bit          obs_to, obs_ctrl_stable;

    function automatic logic [21:0] dut_ctrl();
        return {bif.CIn, bif.SUB, bif.ZeroA, bif.FAOut, bif.AND, bif.OR, bif.XOR, bif.NOT,
                bif.NAND, bif.NOR, bif.Sign, bif.ShSignIn, bif.Sh1, bif.Sh2, bif.Sh4, bif.Sh8,
                bif.ShB, bif.ShL, bif.ShR, bif.ShOut, bif.LLI, bif.ALUEnable};
    endfunction

    // Expected control word straight from the opcode table (same bit order as dut_ctrl)
    function automatic logic [21:0] ctrl_of(input logic [3:0] op, input logic [3:0] sh, input logic fc);
        logic cin, sub, za, fa, an, orr, xo, nt, na, no, sg, ssi, sl, sr, so, ll;
        logic [3:0] shb;
        {cin, sub, za, fa, an, orr, xo, nt, na, no, sg, ssi, sl, sr, so, ll} = '0;
        shb = 4'd0;
        fa  = (op <= 4'd5);
        case (op)
            4'd1:  cin = fc;
            4'd2:  begin sub = 1'b1; cin = 1'b1; end
            4'd3:  begin sub = 1'b1; cin = fc; end
            4'd4:  begin za = 1'b1; sub = 1'b1; cin = 1'b1; end
            4'd5:  za = 1'b1;
            4'd6:  an = 1'b1;
            4'd7:  orr = 1'b1;
            4'd8:  xo = 1'b1;
            4'd9:  nt = 1'b1;
            4'd10: na = 1'b1;
            4'd11: no = 1'b1;
            4'd12: begin sl = 1'b1; so = 1'b1; shb = sh; end
            4'd13: begin sr = 1'b1; so = 1'b1; shb = sh; end
            4'd14: begin sr = 1'b1; sg = 1'b1; ssi = 1'b1; so = 1'b1; shb = sh; end
            4'd15: begin ll = 1'b1; so = 1'b1; end
            default: ;
        endcase
        return {cin, sub, za, fa, an, orr, xo, nt, na, no, sg, ssi,
                shb[0], shb[1], shb[2], shb[3], 1'b0, sl, sr, so, ll, 1'b1};
    endfunction

    // Op-level reference: plain arithmetic on the operands, then update the flag model
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh);
        int s;
        logic [15:0] r;
        logic c;
        c = m_c;
        r = '0;
        exp_ctrl = ctrl_of(op, sh, m_c);
        case (op)
            4'd0:  begin s = int'(a) + int'(b); r = 16'(s); c = (s > 65535); end
            4'd1:  begin s = int'(a) + int'(b) + (m_c ? 1 : 0); r = 16'(s); c = (s > 65535); end
            4'd2:  begin s = int'(a) - int'(b); r = 16'(s); c = (s >= 0); end
            4'd3:  begin s = int'(a) - int'(b) - (m_c ? 0 : 1); r = 16'(s); c = (s >= 0); end
            4'd4:  begin s = 0 - int'(b); r = 16'(s); c = (b == 16'd0); end
            4'd5:  begin r = b; c = 1'b0; end
            4'd6:  r = a & b;
            4'd7:  r = a | b;
            4'd8:  r = a ^ b;
            4'd9:  r = ~a;
            4'd10: r = ~(a & b);
            4'd11: r = ~(a | b);
            4'd12: r = a << sh;
            4'd13: r = a >> sh;
            4'd14: r = 16'($signed(a) >>> sh);
            default: r = {a[15:8], b[7:0]};
        endcase
        exp_res = r;
        m_c = c;
        m_z = (r == 16'd0);
        m_n = r[15];
    endtask

    // Issue one op from IDLE, scramble inputs after acceptance, observe until Done (bounded)
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh);
        @(negedge clk);
        bif.Start = 1'b1; bif.Op = op; bif.OpA = a; bif.OpB = b; bif.ShAmt = sh;
        model(op, a, b, sh);
        @(negedge clk);
        bif.Start = 1'b0;
        bif.Op = 4'($urandom); bif.OpA = 16'($urandom); bif.OpB = 16'($urandom); bif.ShAmt = 4'($urandom);
        obs_to = 1'b1; obs_busy = 0; obs_cyc = 0; obs_ctrl_stable = 1'b1;
        obs_a = bif.A; obs_b = bif.B; obs_ctrl = dut_ctrl(); obs_ctrl_done = '1;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (bif.Busy) obs_busy++;
            if (bif.Done) begin
                obs_cyc = i; obs_res = bif.Result;
                obs_c = bif.FlagC; obs_z = bif.FlagZ; obs_n = bif.FlagN;
                obs_ctrl_done = dut_ctrl(); obs_to = 1'b0;
                break;
            end
            if (dut_ctrl() !== obs_ctrl) obs_ctrl_stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        bif.Start = 1'b0; bif.Op = '0; bif.ShAmt = '0; bif.OpA = '0; bif.OpB = '0;
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bif.Busy !== 1'b0 || bif.Done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", bif.Busy, bif.Done); end
        checks++; if (bif.Result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", bif.Result); end
        checks++; if ({bif.FlagC, bif.FlagZ, bif.FlagN} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bif.FlagC, bif.FlagZ, bif.FlagN}); end
        checks++; if (bif.A !== 16'h0 || bif.B !== 16'h0) begin errors++; $display("FAIL reset_ab got %h %h want 0000 0000", bif.A, bif.B); end
        checks++; if (dut_ctrl() !== 22'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", dut_ctrl()); end
        nreset = 1'b1;
        m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    endtask

    task automatic test_add();
        do_op(4'd0, 16'd16328, 16'd9000, 4'd0);
        checks++; if (obs_to) begin errors++; $display("FAIL add_timeout got no Done want Done"); end
        checks++; if (obs_cyc != SETTLE + 1) begin errors++; $display("FAIL add_latency got %0d want %0d", obs_cyc, SETTLE + 1); end
        checks++; if (obs_busy != SETTLE + 1) begin errors++; $display("FAIL add_busy got %0d want %0d", obs_busy, SETTLE + 1); end
        checks++; if (obs_res !== 16'd25328) begin errors++; $display("FAIL add_result got %0d want 25328", obs_res); end
        checks++; if ({obs_c, obs_z, obs_n} !== {m_c, m_z, m_n}) begin errors++; $display("FAIL add_flags got %b want %b", {obs_c, obs_z, obs_n}, {m_c, m_z, m_n}); end
        checks++; if (obs_ctrl !== exp_ctrl) begin errors++; $display("FAIL add_ctrl got %h want %h", obs_ctrl, exp_ctrl); end
    endtask

    task automatic test_carry();
        do_op(4'd0, 16'hFFFF, 16'h0001, 4'd0);
        checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL carry_result got %h want %h", obs_res, exp_res); end
        checks++; if ({obs_c, obs_z} !== 2'b11) begin errors++; $display("FAIL carry_cz got %b want 11", {obs_c, obs_z}); end
        do_op(4'd1, 16'h0001, 16'h0001, 4'd0);
        checks++; if (obs_ctrl[21] !== 1'b1) begin errors++; $display("FAIL adc_cin got %b want 1", obs_ctrl[21]); end
        checks++; if (obs_res !== 16'd3 || obs_z !== 1'b0) begin errors++; $display("FAIL adc_result got %h z%b want 0003 z0", obs_res, obs_z); end
    endtask

    task automatic test_shift();
        do_op(4'd12, 16'h3FC8, 16'h1234, 4'd3);
        checks++; if (obs_ctrl !== exp_ctrl) begin errors++; $display("FAIL lsl_ctrl got %h want %h", obs_ctrl, exp_ctrl); end
        checks++; if (obs_res !== 16'hFE40) begin errors++; $display("FAIL lsl_result got %h want fe40", obs_res); end
        checks++; if (obs_c !== m_c) begin errors++; $display("FAIL lsl_carry_kept got %b want %b", obs_c, m_c); end
        do_op(4'd14, 16'hFFE9, 16'h0000, 4'd15);
        checks++; if (obs_res !== 16'hFFFF || obs_n !== 1'b1) begin errors++; $display("FAIL asr_result got %h n%b want ffff n1", obs_res, obs_n); end
        do_op(4'd13, 16'h8001, 16'h0000, 4'd0);
        checks++; if (obs_res !== 16'h8001) begin errors++; $display("FAIL lsr_zero_shift got %h want 8001", obs_res); end
    endtask

    task automatic test_lli();
        do_op(4'd15, 16'h3FC8, 16'h0043, 4'd7);
        checks++; if (obs_ctrl !== exp_ctrl) begin errors++; $display("FAIL lli_ctrl got %h want %h", obs_ctrl, exp_ctrl); end
        checks++; if (obs_res !== 16'h3F43) begin errors++; $display("FAIL lli_result got %h want 3f43", obs_res); end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        logic prev_busy;
        logic [15:0] pa, pb;
        logic [3:0] pop, psh;
        @(negedge clk);
        prev_busy = bif.Busy;
        pop = 4'd0; pa = 16'($urandom); pb = 16'($urandom); psh = 4'($urandom);
        bif.Start = 1'b1; bif.Op = pop; bif.OpA = pa; bif.OpB = pb; bif.ShAmt = psh;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (!prev_busy && bif.Busy) begin
                acc.push_back(cyc);
                checks++; if (bif.A !== pa || bif.B !== pb) begin errors++; $display("FAIL b2b_operands got %h %h want %h %h", bif.A, bif.B, pa, pb); end
                model(pop, pa, pb, psh);
            end
            if (bif.Done) begin
                checks++; if (bif.Result !== exp_res) begin errors++; $display("FAIL b2b_result got %h want %h", bif.Result, exp_res); end
            end
            prev_busy = bif.Busy;
            pop = (cyc % 2 == 0) ? 4'd8 : 4'd0;
            pa = 16'($urandom); pb = 16'($urandom); psh = 4'($urandom);
            bif.Op = pop; bif.OpA = pa; bif.OpB = pb; bif.ShAmt = psh;
        end
        bif.Start = 1'b0;
        checks++; if (acc.size() != 24 / (SETTLE + 2)) begin errors++; $display("FAIL b2b_accept_count got %0d want %0d", acc.size(), 24 / (SETTLE + 2)); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++; if (acc[i] - acc[i-1] != SETTLE + 2) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", acc[i] - acc[i-1], SETTLE + 2); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        do_op(4'd0, 16'hFFFF, 16'h8001, 4'd0);
        @(negedge clk);
        bif.Start = 1'b1; bif.Op = 4'd0; bif.OpA = 16'd5; bif.OpB = 16'd6;
        @(negedge clk);
        bif.Start = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        checks++; if (bif.Busy !== 1'b0 || bif.ALUEnable !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy%b en%b want 0 0", bif.Busy, bif.ALUEnable); end
        checks++; if (dut_ctrl() !== 22'h0) begin errors++; $display("FAIL midrst_ctrl got %h want 0", dut_ctrl()); end
        checks++; if (bif.Result !== 16'h0 || {bif.FlagC, bif.FlagZ, bif.FlagN} !== 3'b000) begin errors++; $display("FAIL midrst_state got %h %b want 0000 000", bif.Result, {bif.FlagC, bif.FlagZ, bif.FlagN}); end
        checks++; if (bif.A !== 16'h0 || bif.B !== 16'h0) begin errors++; $display("FAIL midrst_ab got %h %h want 0000 0000", bif.A, bif.B); end
        nreset = 1'b1;
        m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bif.Done) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midrst_done got pulse want none"); end
    endtask

    task automatic test_random();
        logic [3:0] op, sh;
        logic [15:0] a, b;
        for (int n = 0; n < 40; n++) begin
            op = 4'(n % 16);
            if (n >= 16) op = 4'($urandom);
            a = 16'($urandom); b = 16'($urandom); sh = 4'($urandom);
            if (n % 7 == 3) sh = 4'd0;
            if (n % 9 == 5) b = a;
            do_op(op, a, b, sh);
            checks++; if (obs_to) begin errors++; $display("FAIL rnd_timeout op%0d got no Done want Done", op); end
            checks++; if (obs_cyc != SETTLE + 1) begin errors++; $display("FAIL rnd_latency op%0d got %0d want %0d", op, obs_cyc, SETTLE + 1); end
            checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL rnd_result op%0d got %h want %h", op, obs_res, exp_res); end
            checks++; if ({obs_c, obs_z, obs_n} !== {m_c, m_z, m_n}) begin errors++; $display("FAIL rnd_flags op%0d got %b want %b", op, {obs_c, obs_z, obs_n}, {m_c, m_z, m_n}); end
            checks++; if (obs_ctrl !== exp_ctrl || !obs_ctrl_stable) begin errors++; $display("FAIL rnd_ctrl op%0d got %h stable%b want %h", op, obs_ctrl, obs_ctrl_stable, exp_ctrl); end
            checks++; if (obs_ctrl_done !== 22'h0) begin errors++; $display("FAIL rnd_done_ctrl op%0d got %h want 0", op, obs_ctrl_done); end
            checks++; if (obs_a !== a || obs_b !== b) begin errors++; $display("FAIL rnd_operands op%0d got %h %h want %h %h", op, obs_a, obs_b, a, b); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_shift();
        test_lli();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
